jpeg_stream_framer: RTL
=======================

# jpeg_stream_framer

Transmit-side framer for the length-prefixed 32-bit word stream consumed by the JPEG image-preprocessing front end. It accepts a JPEG file as a byte stream with an end-of-file marker and buffers one whole frame. It then emits a header word holding the frame's word count, followed by the little-endian packed data words. Sits between the host/byte source and the preprocessing input port, and reuses that port's valid/stall handshake.

## Interface
- MAX_WORDS, 4096: buffer capacity in 32-bit words (power of two, ≥ 4).
- AW, $clog2(MAX_WORDS): buffer address width (derived, do not override).

- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_byte  in  8  JPEG file byte.
- in_valid  in  1  in_byte valid this cycle.
- in_last  in  1  qualifies in_byte as final byte of file; meaningful only with in_valid.
- upstream_stall  out  1  high = byte not accepted this cycle.
- out_data  out  32  header word or data word.
- out_valid  out  1  out_data valid.
- downstream_stall  in  1  high = sink cannot take out_data this cycle.
- overflow  out  1  one-cycle pulse: last frame truncated.

## Operation
- Byte transfer: in_valid && !upstream_stall. Word transfer: out_valid && !downstream_stall.
- States: FILL, HEADER, DRAIN.
- FILL: upstream_stall = 0. Accepted bytes are packed little-endian (1st byte → [7:0], 4th → [31:24]). The word is written to buffer[wr_ptr] when the 4th byte is accepted, or when in_last is accepted (partial word zero-padded in its upper bytes). wr_ptr increments per write.
- Word count = ceil(bytes/4). Count is 32 bits, zero-extended from AW+1 bits.
- Overflow: once MAX_WORDS words are written, further bytes are still accepted but discarded until in_last. Header count = MAX_WORDS. overflow pulses for the one cycle when HEADER is entered.
- Accepted in_last → HEADER on the next cycle.
- HEADER: out_valid = 1, out_data = word count, upstream_stall = 1. On transfer → DRAIN with rd_ptr = 0.
- DRAIN: out_valid = 1, out_data = buffer[rd_ptr], upstream_stall = 1. Each transfer increments rd_ptr. The transfer of word count−1 → FILL, clearing wr_ptr, the packer and the byte lane.
- A frame always has ≥ 1 byte (in_last rides a valid byte), so DRAIN is never empty.
- While out_valid && downstream_stall: out_data and out_valid hold stable; no word is dropped or repeated.
- Buffer may be register array or synchronous RAM. If RAM, use a lookahead read so that DRAIN still sustains one word per cycle.

## Timing
- Reset values: out_valid 0, out_data 0, upstream_stall 0, overflow 0, state FILL, all pointers and the packer cleared. Reset mid-frame discards all buffered data.
- in_last accepted at cycle T → header out_valid at T+1. upstream_stall = 1 from T+1.
- With downstream_stall held low: header at T+1, data word k at T+2+k. No bubbles.
- Last data word transfers at cycle L → state FILL and upstream_stall = 0 at L+1. A byte offered at L+1 is accepted.
- Frame latency = bytes + 1 + words cycles, minimum, with no stalls on either side.
- upstream_stall and out_valid are registered (state-decoded). in_valid in HEADER/DRAIN is ignored: no capture and no side effect.

## Test plan
- 8 bytes 0x01..0x08, in_last on 8th, no stall → out: 0x00000002, 0x04030201, 0x08070605 on consecutive cycles; upstream_stall high exactly from T+1 through the last word's cycle.
- 5 bytes 0x11..0x15 → out: 0x00000002, 0x14131211, 0x00000015.
- 1 byte 0xAB with in_last → out: 0x00000001, 0x000000AB; back in FILL 3 cycles after the byte.
- 12-byte frame with downstream_stall toggled pseudo-randomly → exactly 4 transfers in order; out_data constant across every stalled cycle.
- MAX_WORDS=4, 20 bytes → upstream_stall stays 0 for all 20 bytes; header 0x00000004 plus first 4 packed words; overflow high for one cycle coincident with the header.
- reset asserted during DRAIN of frame A → next cycle out_valid 0 and upstream_stall 0; following frame B is emitted correctly with no residue of A.

Source files
------------

// File: rtl/jpeg_stream_framer.sv
// jpeg_stream_framer: buffers one JPEG file arriving as bytes, then sends a
// word-count header followed by the little-endian packed 32-bit data words.
module jpeg_stream_framer #(
  parameter int MAX_WORDS = 4096,
  parameter int AW        = $clog2(MAX_WORDS)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        upstream_stall,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        downstream_stall,
  output logic        overflow
);

  typedef enum logic [1:0] {
    FILL,
    HEADER,
    DRAIN
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(MAX_WORDS);

  state_t      state;
  state_t      state_next;

  logic [AW:0]   word_count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [31:0]   pack;
  logic [1:0]    lane;
  logic          dropped;
  logic [31:0]   merged;
  logic [31:0]   rd_word;
  logic [31:0]   mem [MAX_WORDS];

  logic byte_take;
  logic word_take;
  logic buf_full;
  logic last_word;
  logic write_en;

  // Handshake and bookkeeping decodes; both stall and valid follow the state register.
  assign out_valid      = (state != FILL);
  assign upstream_stall = (state != FILL);
  assign byte_take      = in_valid && (state == FILL);
  assign word_take      = out_valid && !downstream_stall;
  assign buf_full       = (word_count == FULL_COUNT);
  assign last_word      = ({1'b0, rd_ptr} == (word_count - 1'b1));
  assign write_en       = byte_take && !buf_full && ((lane == 2'd3) || in_last);

  // Insert the incoming byte into its lane of the partially packed word.
  always_comb begin
    merged = pack;
    merged[{lane, 3'b000} +: 8] = in_byte;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the lookahead read pointer that keeps DRAIN gap-free.
  always_comb begin
    state_next  = state;
    rd_ptr_next = rd_ptr;
    case (state)
      FILL: begin
        if (byte_take && in_last) begin
          state_next = HEADER;
        end
      end
      HEADER: begin
        if (word_take) begin
          state_next  = DRAIN;
          rd_ptr_next = '0;
        end
      end
      DRAIN: begin
        if (word_take) begin
          rd_ptr_next = rd_ptr + 1'b1;
          if (last_word) begin
            state_next = FILL;
          end
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Output word select: header count, buffered data, or zero while filling.
  always_comb begin
    out_data = 32'd0;
    case (state)
      HEADER:  out_data = 32'(word_count);
      DRAIN:   out_data = rd_word;
      default: out_data = 32'd0;
    endcase
  end

  // Byte packing, word counting, truncation tracking and read pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_count <= '0;
      rd_ptr     <= '0;
      pack       <= 32'd0;
      lane       <= 2'd0;
      dropped    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      rd_ptr   <= rd_ptr_next;
      if (byte_take) begin
        if (buf_full) begin
          dropped <= 1'b1;
        end else if (write_en) begin
          word_count <= word_count + 1'b1;
          pack       <= 32'd0;
          lane       <= 2'd0;
        end else begin
          pack <= merged;
          lane <= lane + 1'b1;
        end
        if (in_last) begin
          overflow <= dropped || buf_full;
          dropped  <= 1'b0;
          pack     <= 32'd0;
          lane     <= 2'd0;
        end
      end
      if ((state == DRAIN) && word_take && last_word) begin
        word_count <= '0;
      end
    end
  end

  // Frame buffer as synchronous RAM; the read address is the next pointer so data lines up.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[word_count[AW-1:0]] <= merged;
    end
    rd_word <= mem[rd_ptr_next];
  end

endmodule
